uart_ctrl_tx: RTL and testbench
===============================

UART_CTRL_TX -- requirements
Module: uart_ctrl_tx

Interface
REQ-001 SHALL have parameter SAMPLES_PER_BIT, default 5, the number of io_samplingTick pulses per UART bit (range 2..8).
REQ-002 SHALL have port io_mainClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port resetCtrl_systemReset, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port io_configFrame_dataLength, input, 3 bits: data bits minus one (0..7 gives 1..8 bits).
REQ-005 SHALL have port io_configFrame_stop, input, 1 bit: stop bits, 0=ONE, 1=TWO.
REQ-006 SHALL have port io_configFrame_parity, input, 2 bits: parity, 0=NONE, 1=EVEN, 2=ODD; 3 is treated as NONE.
REQ-007 SHALL have port io_samplingTick, input, 1 bit: one-cycle oversampling strobe shared with the receiver.
REQ-008 SHALL have port io_write_valid, input, 1 bit: a byte is offered.
REQ-009 SHALL have port io_write_ready, output, 1 bit: a one-cycle accept strobe.
REQ-010 SHALL have port io_write_payload, input, 8 bits: the byte to send, LSB first; bits above dataLength are ignored.
REQ-011 SHALL have port io_cts, input, 1 bit: 1 = peer not ready, so no new frame starts.
REQ-012 SHALL have port io_break, input, 1 bit: request to hold the line low.
REQ-013 SHALL have port io_txd, output, 1 bit: serial line, registered, idle high.
REQ-014 SHALL have port io_busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-015 Bit timer SHALL be a counter decremented on each io_samplingTick; bitTick = io_samplingTick while the counter is 0, and the counter then reloads SAMPLES_PER_BIT-1.
REQ-016 The bit timer SHALL free-run in every state, so frames always start aligned to a bitTick.
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP; all transitions occur only on bitTick.
REQ-018 IDLE: on bitTick with io_write_valid=1, io_cts=0 and io_break=0, the block SHALL assert io_write_ready for that cycle, capture io_write_payload into the shifter, and go to START.
REQ-019 START SHALL drive io_txd=0 for one bit, clear bitCounter, set parity seed = (parity==ODD), then go to DATA.
REQ-020 DATA SHALL drive io_txd=shifter[bitCounter] and fold that bit into the parity accumulator (XOR).
REQ-021 At bitCounter==dataLength, DATA SHALL go to PARITY if parity is EVEN or ODD, else to STOP, clearing bitCounter; otherwise bitCounter increments.
REQ-022 PARITY SHALL drive io_txd = accumulated parity for one bit, then go to STOP with bitCounter cleared.
REQ-023 STOP SHALL drive io_txd=1 for 1 bit (ONE) or 2 bits (TWO), counting with bitCounter, then go to IDLE.
REQ-024 io_txd SHALL be registered from the state and bit value, so the line changes exactly one cycle after the bitTick cycle.
REQ-025 io_break SHALL be honoured only in IDLE: io_txd=0 while io_break=1 and the state is IDLE. A frame in progress completes unaffected, then break applies.
REQ-026 io_cts and the config inputs SHALL be sampled only at the IDLE accept; changing config mid-frame is undefined but SHALL NOT lock up the FSM.
REQ-027 A back-to-back valid SHALL start the next START on the bitTick at which STOP completes, with zero idle bits between frames.
REQ-028 An undefined state encoding SHALL return to IDLE.

Reset
REQ-029 On resetCtrl_systemReset=0 at a clock edge: state=IDLE, io_txd=1, io_write_ready=0, io_busy=0, bit timer=0, bitCounter=0, shifter=0, parity=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with the line high on the next cycle and no ready pulse.

Structure
REQ-031 Shared package uart_pkg SHALL hold the UartStopType, UartParityType and UART FSM state encodings used by both the rx and tx controllers.
REQ-032 No sub-module is required; the bit timer and FSM are inline.

Verification
REQ-033 8N1, payload 0x55, SAMPLES_PER_BIT=5, tick every cycle -> txd 0,1,0,1,0,1,0,1,0,1, each bit 5 cycles; one ready pulse; busy for 50 cycles.
REQ-034 7E2, payload 0x83 (7 bits 0x03) -> start, 1,1,0,0,0,0,0, parity 0, stop 1,1; then IDLE.
REQ-035 8O1, payload 0xFF -> parity bit 1; back-to-back second byte 0x00 -> its start bit follows the stop bit with no gap, and its parity bit is 1.
REQ-036 io_cts=1 with valid held for 100 bit times -> no ready and txd stays 1; drop cts -> frame starts at the next bitTick.
REQ-037 io_break raised mid-frame -> frame completes normally, then txd=0 until break drops; pull reset low mid-DATA -> txd=1 and state IDLE one cycle later.

Source files
------------

// File: rtl/uart_pkg.sv
// UART types shared by the rx and tx controllers:
// frame configuration enums and the controller FSM state encoding.
package uart_pkg;

    typedef enum logic {
        UART_STOP_ONE = 1'b0,
        UART_STOP_TWO = 1'b1
    } UartStopType;

    typedef enum logic [1:0] {
        UART_PARITY_NONE = 2'd0,
        UART_PARITY_EVEN = 2'd1,
        UART_PARITY_ODD  = 2'd2
    } UartParityType;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } UartCtrlState;

endpackage

// File: rtl/uart_ctrl_tx.sv
// UART transmit controller: free-running bit timer plus frame FSM,
// registered txd output, break and cts flow control handled in IDLE.
module uart_ctrl_tx
    import uart_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 5
) (
    input  logic       io_mainClk,
    input  logic       resetCtrl_systemReset,
    input  logic [2:0] io_configFrame_dataLength,
    input  logic       io_configFrame_stop,
    input  logic [1:0] io_configFrame_parity,
    input  logic       io_samplingTick,
    input  logic       io_write_valid,
    output logic       io_write_ready,
    input  logic [7:0] io_write_payload,
    input  logic       io_cts,
    input  logic       io_break,
    output logic       io_txd,
    output logic       io_busy
);

    localparam logic [2:0] RELOAD = 3'(SAMPLES_PER_BIT - 1);

    UartCtrlState  state_q, state_d;
    UartStopType   stop_q, stop_d;
    UartParityType par_q, par_d;
    logic [2:0]    timer_q, timer_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [2:0]    len_q, len_d;
    logic [7:0]    shifter_q, shifter_d;
    logic          parity_q, parity_d;
    logic          txd_q, txd_d;
    logic          bit_tick;
    logic          can_start;
    logic          start_frame;
    logic          ready_c;

    always_comb begin
        bit_tick    = io_samplingTick && (timer_q == 3'd0);
        can_start   = bit_tick && io_write_valid && !io_cts && !io_break;
        timer_d     = timer_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        stop_d      = stop_q;
        par_d       = par_q;
        shifter_d   = shifter_q;
        parity_d    = parity_q;
        start_frame = 1'b0;
        ready_c     = 1'b0;

        if (io_samplingTick) begin
            timer_d = (timer_q == 3'd0) ? RELOAD : timer_q - 3'd1;
        end

        unique case (state_q)
            UART_IDLE: begin
                start_frame = can_start;
            end
            UART_START: begin
                if (bit_tick) begin
                    state_d  = UART_DATA;
                    cnt_d    = 3'd0;
                    parity_d = (par_q == UART_PARITY_ODD);
                end
            end
            UART_DATA: begin
                if (bit_tick) begin
                    parity_d = parity_q ^ shifter_q[cnt_q];
                    if (cnt_q == len_q) begin
                        cnt_d   = 3'd0;
                        state_d = (par_q == UART_PARITY_NONE) ?
                                  UART_STOP : UART_PARITY;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            UART_PARITY: begin
                if (bit_tick) begin
                    state_d = UART_STOP;
                    cnt_d   = 3'd0;
                end
            end
            UART_STOP: begin
                if (bit_tick) begin
                    if (stop_q == UART_STOP_TWO && cnt_q == 3'd0) begin
                        cnt_d = 3'd1;
                    end else begin
                        cnt_d       = 3'd0;
                        state_d     = UART_IDLE;
                        start_frame = can_start;
                    end
                end
            end
            default: begin
                state_d = UART_IDLE;
            end
        endcase

        // Accept path shared by IDLE and a completing STOP (back-to-back).
        if (start_frame) begin
            ready_c   = 1'b1;
            state_d   = UART_START;
            shifter_d = io_write_payload;
            len_d     = io_configFrame_dataLength;
            stop_d    = UartStopType'(io_configFrame_stop);
            par_d     = (io_configFrame_parity == 2'd1 ||
                         io_configFrame_parity == 2'd2) ?
                        UartParityType'(io_configFrame_parity) :
                        UART_PARITY_NONE;
        end

        unique case (state_q)
            UART_IDLE:   txd_d = ~io_break;
            UART_START:  txd_d = 1'b0;
            UART_DATA:   txd_d = shifter_q[cnt_q];
            UART_PARITY: txd_d = parity_q;
            UART_STOP:   txd_d = 1'b1;
            default:     txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge io_mainClk) begin
        if (!resetCtrl_systemReset) begin
            state_q   <= UART_IDLE;
            timer_q   <= 3'd0;
            cnt_q     <= 3'd0;
            len_q     <= 3'd0;
            stop_q    <= UART_STOP_ONE;
            par_q     <= UART_PARITY_NONE;
            shifter_q <= 8'd0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            stop_q    <= stop_d;
            par_q     <= par_d;
            shifter_q <= shifter_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
        end
    end

    assign io_write_ready = ready_c && resetCtrl_systemReset;
    assign io_txd         = txd_q;
    assign io_busy        = (state_q != UART_IDLE);

endmodule

// File: tb/tb_uart_ctrl_tx.sv
// Self-checking bench for uart_ctrl_tx: frames are predicted as a
// flat list of line bits from payload and config, each SPB cycles long.
module tb_uart_ctrl_tx;

    localparam int SPB = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] dl;
    logic       stp;
    logic [1:0] par;
    logic       tick;
    logic       valid;
    logic       ready;
    logic [7:0] payload;
    logic       cts;
    logic       brk;
    logic       txd;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] plq[$];
    bit         expq[$];

    always #5 clk = ~clk;

    uart_ctrl_tx #(.SAMPLES_PER_BIT(SPB)) dut (
        .io_mainClk                (clk),
        .resetCtrl_systemReset     (rst_n),
        .io_configFrame_dataLength (dl),
        .io_configFrame_stop       (stp),
        .io_configFrame_parity     (par),
        .io_samplingTick           (tick),
        .io_write_valid            (valid),
        .io_write_ready            (ready),
        .io_write_payload          (payload),
        .io_cts                    (cts),
        .io_break                  (brk),
        .io_txd                    (txd),
        .io_busy                   (busy)
    );

    function automatic void add_frame(logic [7:0] d, logic [2:0] n,
                                      logic s, logic [1:0] p);
        int ones;
        ones = 0;
        expq.push_back(1'b0);
        for (int i = 0; i <= int'(n); i++) begin
            expq.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (p == 2'd1) expq.push_back(ones % 2 == 1);
        else if (p == 2'd2) expq.push_back(ones % 2 == 0);
        expq.push_back(1'b1);
        if (s) expq.push_back(1'b1);
    endfunction

    // Offers every byte of plq back to back and checks the line bit by bit.
    task automatic run_frames(input logic [2:0] n, input logic s,
                              input logic [1:0] p, input int bound,
                              input string name);
        int idx, nready, nbusy, nbad, first_b;
        bit got, first_got, first_want;
        expq.delete();
        foreach (plq[k]) add_frame(plq[k], n, s, p);
        dl = n; stp = s; par = p;
        payload = plq[0]; valid = 1'b1; idx = 1; got = 1'b0;
        #1;
        for (int i = 0; i < bound && !got; i++) begin
            if (ready === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        if (!got && ready === 1'b1) got = 1'b1;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s first_ready: ready=0 after %0d cycles, want 1",
                     name, bound);
            valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (idx < plq.size()) begin payload = plq[idx]; idx++; end
        else valid = 1'b0;
        nready = 1; nbusy = 0; nbad = 0; first_b = -1;
        first_got = 1'b0; first_want = 1'b0;
        @(negedge clk);
        if (busy === 1'b1) nbusy++;
        for (int b = 0; b < expq.size(); b++) begin
            for (int j = 0; j < SPB; j++) begin
                @(negedge clk);
                if (busy === 1'b1) nbusy++;
                if (txd !== expq[b]) begin
                    if (nbad == 0) begin
                        first_b = b; first_got = txd; first_want = expq[b];
                    end
                    nbad++;
                end
                if (ready === 1'b1) begin
                    nready++;
                    @(posedge clk); #1;
                    if (idx < plq.size()) begin
                        payload = plq[idx]; idx++;
                    end else valid = 1'b0;
                end
            end
        end
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL %s txd: %0d bad cycles, bit %0d got %b want %b",
                     name, nbad, first_b, first_got, first_want);
        end
        checks++;
        if (nready != plq.size()) begin
            failures++;
            $display("FAIL %s ready_count: got %0d want %0d",
                     name, nready, plq.size());
        end
        checks++;
        if (nbusy != expq.size() * SPB) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d want %0d",
                     name, nbusy, expq.size() * SPB);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s end_busy: got %b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL reset: txd=%b busy=%b ready=%b want 1 0 0",
                     txd, busy, ready);
        end
        valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_8n1();
        plq = {8'h55};
        run_frames(3'd7, 1'b0, 2'd0, 200, "8n1_55");
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin
            failures++;
            $display("FAIL 8n1_idle_txd: got %b want 1", txd);
        end
    endtask

    task automatic test_7e2();
        plq = {8'h83};
        run_frames(3'd6, 1'b1, 2'd1, 200, "7e2_83");
    endtask

    task automatic test_back_to_back();
        plq = {8'hFF, 8'h00};
        run_frames(3'd7, 1'b0, 2'd2, 200, "8o1_b2b");
    endtask

    task automatic test_cts();
        int nbad;
        nbad = 0;
        cts = 1'b1; valid = 1'b1; payload = 8'hA5;
        dl = 3'd7; stp = 1'b0; par = 2'd0;
        repeat (100 * SPB) begin
            @(negedge clk);
            if (ready !== 1'b0 || txd !== 1'b1) nbad++;
        end
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL cts_hold: %0d cycles with ready/txd active, want 0",
                     nbad);
        end
        cts = 1'b0;
        plq = {8'hA5};
        run_frames(3'd7, 1'b0, 2'd0, SPB, "cts_release");
    endtask

    task automatic test_break();
        int nbad;
        plq = {8'h3C};
        fork
            run_frames(3'd7, 1'b0, 2'd1, 200, "break_frame");
            begin
                repeat (25) @(negedge clk);
                brk = 1'b1;
            end
        join
        nbad = 0;
        valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (txd !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) nbad++;
        end
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL break_hold: %0d bad cycles, want txd=0 idle", nbad);
        end
        valid = 1'b0;
        brk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin
            failures++;
            $display("FAIL break_release: txd=%b want 1", txd);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        dl = 3'd7; stp = 1'b0; par = 2'd0;
        payload = 8'h00; valid = 1'b1; got = 1'b0;
        #1;
        for (int i = 0; i < 50 && !got; i++) begin
            if (ready === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rst_mid_accept: ready=0, want 1");
        end
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (4 * SPB) @(negedge clk);
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_data: txd=%b busy=%b want 0 1", txd, busy);
        end
        rst_n = 1'b0; valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_abort: txd=%b busy=%b ready=%b want 1 0 0",
                     txd, busy, ready);
        end
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0] n;
        logic       s;
        logic [1:0] p;
        int         cnt;
        for (int it = 0; it < 15; it++) begin
            n   = 3'($urandom_range(0, 7));
            s   = 1'($urandom_range(0, 1));
            p   = 2'($urandom_range(0, 3));
            cnt = $urandom_range(1, 3);
            plq.delete();
            for (int k = 0; k < cnt; k++) plq.push_back(8'($urandom));
            run_frames(n, s, p, 200, $sformatf("rand%0d", it));
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b1; valid = 1'b0; payload = 8'h00;
        cts = 1'b0; brk = 1'b0; dl = 3'd7; stp = 1'b0; par = 2'd0;
        test_reset();
        test_8n1();
        test_7e2();
        test_back_to_back();
        test_cts();
        test_break();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
